// File: rtl/xbar_pkg.sv
// Shared sizes, arbiter state encoding and index helper for the 5x5 Avalon-MM crossbar.
package xbar_pkg;
  localparam int NUM_MASTERS = 5;
  localparam int NUM_SLAVES  = 5;
  localparam int ADDR_W      = 30;
  localparam int DATA_W      = 32;
  localparam int BURST_W     = 8;
  localparam int BE_W        = DATA_W / 8;
  localparam int MIDX_W      = $clog2(NUM_MASTERS);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Master index `base + off`, wrapped into 0..NUM_MASTERS-1.
  function automatic logic [MIDX_W-1:0] wrap_idx(input logic [MIDX_W-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_MASTERS) t = t - NUM_MASTERS;
    return MIDX_W'(t);
  endfunction
endpackage

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbiter: locks one master for a whole burst and counts its accepted beats.
// XBAR_ROUND_ROBIN_EN selects round-robin search; otherwise the lowest master index wins.
module xbar_slave_arbiter
  import xbar_pkg::*;
(
  input  logic                                i_Clk,
  input  logic                                i_Rst_n,
  input  logic [NUM_MASTERS-1:0]              i_Req,
  input  logic [NUM_MASTERS-1:0]              i_Active,
  input  logic [NUM_MASTERS-1:0][BURST_W-1:0] i_BurstCount,
  input  logic                                i_WaitRequest,
  output logic [MIDX_W-1:0]                   o_Owner,
  output logic                                o_Busy
);
  arb_state_e         r_state, w_state_nxt;
  logic [MIDX_W-1:0]  r_owner, w_owner_nxt;
  logic [BURST_W-1:0] r_beats, w_beats_nxt;
  logic [MIDX_W-1:0]  w_win, w_idx;
  logic               w_found, w_accept;

`ifdef XBAR_ROUND_ROBIN_EN
  logic [MIDX_W-1:0]  r_ptr;
`endif

  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
`ifdef XBAR_ROUND_ROBIN_EN
      w_idx = wrap_idx(r_ptr, i);
`else
      w_idx = MIDX_W'(i);
`endif
      if (!w_found && i_Req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_beats_nxt = r_beats;
    w_accept    = i_Active[r_owner] & ~i_WaitRequest;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt = ARB_BUSY;
          w_owner_nxt = w_win;
          // a zero burstcount still moves one beat
          w_beats_nxt = (i_BurstCount[w_win] == '0) ? BURST_W'(1) : i_BurstCount[w_win];
        end
      end
      ARB_BUSY: begin
        if (w_accept) begin
          if (r_beats <= BURST_W'(1)) begin
            w_state_nxt = ARB_IDLE;
            w_beats_nxt = '0;
          end else begin
            w_beats_nxt = r_beats - BURST_W'(1);
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_beats <= w_beats_nxt;
    end
  end

`ifdef XBAR_ROUND_ROBIN_EN
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n)
      r_ptr <= '0;
    else if (r_state == ARB_IDLE && w_found)
      r_ptr <= wrap_idx(w_win, 1);
  end
`endif

  assign o_Owner = r_owner;
  assign o_Busy  = (r_state == ARB_BUSY);
endmodule

// File: rtl/xbar_interconnect.sv
// 5x5 Avalon-MM crossbar: address decode, per-slave arbiters and combinational data muxes.
// Arbitration policy follows XBAR_ROUND_ROBIN_EN (see xbar_slave_arbiter).
module xbar_interconnect
  import xbar_pkg::*;
#(
  parameter int ADDR_SEL_BITS_O0 = 5,
  parameter int ADDR_SEL_BITS_O1 = 5,
  parameter int ADDR_SEL_BITS_O2 = 5,
  parameter int ADDR_SEL_BITS_O3 = 5,
  parameter int ADDR_SEL_BITS_O4 = 5,
  parameter int ADDR_SEL_O0      = 0,
  parameter int ADDR_SEL_O1      = 1,
  parameter int ADDR_SEL_O2      = 2,
  parameter int ADDR_SEL_O3      = 3,
  parameter int ADDR_SEL_O4      = 4
)(
  input  logic                                i_Clk,
  input  logic                                i_Rst_n,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  i_AVIn_Addr,
  input  logic [NUM_MASTERS-1:0][BE_W-1:0]    i_AVIn_ByteEn,
  input  logic [NUM_MASTERS-1:0]              i_AVIn_Read,
  output logic [NUM_MASTERS-1:0][DATA_W-1:0]  o_AVIn_ReadData,
  input  logic [NUM_MASTERS-1:0]              i_AVIn_Write,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  i_AVIn_WriteData,
  output logic [NUM_MASTERS-1:0]              o_AVIn_WaitRequest,
  input  logic [NUM_MASTERS-1:0][BURST_W-1:0] i_AVIn_BurstCount,
  output logic [NUM_SLAVES-1:0][ADDR_W-1:0]   o_AVOut_Addr,
  output logic [NUM_SLAVES-1:0][BE_W-1:0]     o_AVOut_ByteEn,
  output logic [NUM_SLAVES-1:0]               o_AVOut_Read,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]   i_AVOut_ReadData,
  output logic [NUM_SLAVES-1:0]               o_AVOut_Write,
  output logic [NUM_SLAVES-1:0][DATA_W-1:0]   o_AVOut_WriteData,
  input  logic [NUM_SLAVES-1:0]               i_AVOut_WaitRequest,
  output logic [NUM_SLAVES-1:0][BURST_W-1:0]  o_AVOut_BurstCount
);
  localparam int SEL_BITS [NUM_SLAVES] = '{ADDR_SEL_BITS_O0, ADDR_SEL_BITS_O1, ADDR_SEL_BITS_O2,
                                           ADDR_SEL_BITS_O3, ADDR_SEL_BITS_O4};
  localparam int SEL_VAL  [NUM_SLAVES] = '{ADDR_SEL_O0, ADDR_SEL_O1, ADDR_SEL_O2,
                                           ADDR_SEL_O3, ADDR_SEL_O4};

  logic [NUM_MASTERS-1:0][NUM_SLAVES-1:0] w_hit, w_tgt, w_gnt;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0]                 w_act, w_mapped, w_has_gnt;
  logic [NUM_SLAVES-1:0][MIDX_W-1:0]      w_owner;
  logic [NUM_SLAVES-1:0]                  w_busy;

  for (genvar gm = 0; gm < NUM_MASTERS; gm++) begin : g_mst
    for (genvar gs = 0; gs < NUM_SLAVES; gs++) begin : g_slv
      localparam int SB = SEL_BITS[gs];
      assign w_hit[gm][gs] = (int'(i_AVIn_Addr[gm][ADDR_W-1 -: SB]) == SEL_VAL[gs]);
      assign w_gnt[gm][gs] = w_busy[gs] & (w_owner[gs] == MIDX_W'(gm));
      // a master already holding a grant anywhere does not compete again
      assign w_req[gs][gm] = w_tgt[gm][gs] & w_act[gm] & ~w_has_gnt[gm];
    end
    // lowest matching slave wins: isolate the lowest set hit bit
    assign w_tgt[gm]     = w_hit[gm] & (~w_hit[gm] + NUM_SLAVES'(1));
    assign w_mapped[gm]  = |w_hit[gm];
    assign w_act[gm]     = i_AVIn_Read[gm] | i_AVIn_Write[gm];
    assign w_has_gnt[gm] = |w_gnt[gm];
  end

  for (genvar gs = 0; gs < NUM_SLAVES; gs++) begin : g_arb
    xbar_slave_arbiter u_arb (
      .i_Clk         (i_Clk),
      .i_Rst_n       (i_Rst_n),
      .i_Req         (w_req[gs]),
      .i_Active      (w_act),
      .i_BurstCount  (i_AVIn_BurstCount),
      .i_WaitRequest (i_AVOut_WaitRequest[gs]),
      .o_Owner       (w_owner[gs]),
      .o_Busy        (w_busy[gs])
    );
  end

  always_comb begin
    o_AVOut_Addr       = '0;
    o_AVOut_ByteEn     = '0;
    o_AVOut_Read       = '0;
    o_AVOut_Write      = '0;
    o_AVOut_WriteData  = '0;
    o_AVOut_BurstCount = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (w_busy[s]) begin
        o_AVOut_Addr[s]       = i_AVIn_Addr[w_owner[s]];
        o_AVOut_ByteEn[s]     = i_AVIn_ByteEn[w_owner[s]];
        o_AVOut_Read[s]       = i_AVIn_Read[w_owner[s]];
        o_AVOut_Write[s]      = i_AVIn_Write[w_owner[s]];
        o_AVOut_WriteData[s]  = i_AVIn_WriteData[w_owner[s]];
        o_AVOut_BurstCount[s] = i_AVIn_BurstCount[w_owner[s]];
      end
    end
  end

  // unmapped masters complete immediately; mapped non-owners stall
  always_comb begin
    o_AVIn_WaitRequest = w_mapped;
    o_AVIn_ReadData    = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (w_gnt[m][s]) begin
          o_AVIn_WaitRequest[m] = i_AVOut_WaitRequest[s];
          o_AVIn_ReadData[m]    = i_AVOut_ReadData[s];
        end
      end
    end
  end
endmodule

// File: tb/tb_xbar_interconnect.sv
// Bench for xbar_interconnect: decode table, directed burst/arbitration sequences and
// randomized traffic checked every cycle against a transaction-level crossbar model.
`timescale 1ns/1ps
module tb_xbar_interconnect;
  import xbar_pkg::*;
  localparam int NM = NUM_MASTERS;
  localparam int NS = NUM_SLAVES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0][ADDR_W-1:0]  m_addr;
  logic [NM-1:0][BE_W-1:0]    m_be;
  logic [NM-1:0]              m_rd, m_wr, m_wait;
  logic [NM-1:0][DATA_W-1:0]  m_wdata, m_rdata;
  logic [NM-1:0][BURST_W-1:0] m_bc;
  logic [NS-1:0][ADDR_W-1:0]  s_addr;
  logic [NS-1:0][BE_W-1:0]    s_be;
  logic [NS-1:0]              s_rd, s_wr, s_wait;
  logic [NS-1:0][DATA_W-1:0]  s_wdata, s_rdata;
  logic [NS-1:0][BURST_W-1:0] s_bc;

  xbar_interconnect dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_AVIn_Addr(m_addr), .i_AVIn_ByteEn(m_be), .i_AVIn_Read(m_rd), .o_AVIn_ReadData(m_rdata),
    .i_AVIn_Write(m_wr), .i_AVIn_WriteData(m_wdata), .o_AVIn_WaitRequest(m_wait),
    .i_AVIn_BurstCount(m_bc),
    .o_AVOut_Addr(s_addr), .o_AVOut_ByteEn(s_be), .o_AVOut_Read(s_rd), .i_AVOut_ReadData(s_rdata),
    .o_AVOut_Write(s_wr), .o_AVOut_WriteData(s_wdata), .i_AVOut_WaitRequest(s_wait),
    .o_AVOut_BurstCount(s_bc)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: who owns each slave and how many beats remain
  typedef struct { bit busy; int owner; int left; int ptr; } slot_t;
  slot_t am [NS];
  bit mon_en = 1'b0;

  // top 5 address bits name the slave directly; 5..31 are holes
  function automatic int dec(input logic [ADDR_W-1:0] a);
    int t;
    t = int'(a >> (ADDR_W - 5));
    return (t < NS) ? t : -1;
  endfunction

  function automatic int owned_by(input int m);
    for (int s = 0; s < NS; s++) if (am[s].busy && am[s].owner == m) return s;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        am[s].busy = 0; am[s].owner = 0; am[s].left = 0; am[s].ptr = 0;
      end
      mon_en = 1'b1;
    end else if (mon_en) begin
      int own [NM];
      for (int m = 0; m < NM; m++) own[m] = owned_by(m);
      for (int s = 0; s < NS; s++) begin
        if (am[s].busy) begin
          int o;
          o = am[s].owner;
          if ((m_rd[o] || m_wr[o]) && !s_wait[s]) begin
            if (am[s].left <= 1) am[s].busy = 0;
            else am[s].left = am[s].left - 1;
          end
        end else begin
          int w;
          w = -1;
          for (int i = 0; i < NM; i++) begin
            int c;
`ifdef XBAR_ROUND_ROBIN_EN
            c = (am[s].ptr + i) % NM;
`else
            c = i;
`endif
            if (w < 0 && dec(m_addr[c]) == s && (m_rd[c] || m_wr[c]) && own[c] < 0) w = c;
          end
          if (w >= 0) begin
            am[s].busy  = 1;
            am[s].owner = w;
            am[s].left  = (m_bc[w] == 0) ? 1 : int'(m_bc[w]);
            am[s].ptr   = (w + 1) % NM;
          end
        end
      end
    end
  end

  // every cycle: compare all outputs with what the model says the muxes must show
  logic [NS-1:0][ADDR_W-1:0]  e_addr;
  logic [NS-1:0][BE_W-1:0]    e_be;
  logic [NS-1:0]              e_rd, e_wr;
  logic [NS-1:0][DATA_W-1:0]  e_wdata;
  logic [NS-1:0][BURST_W-1:0] e_bc;
  logic [NM-1:0]              e_wait, a_wait, msk;
  logic [NM-1:0][DATA_W-1:0]  e_rdata, a_rdata;

  always @(negedge clk) begin
    if (mon_en) begin
      e_addr = '0; e_be = '0; e_rd = '0; e_wr = '0; e_wdata = '0; e_bc = '0;
      for (int s = 0; s < NS; s++) begin
        if (am[s].busy) begin
          e_addr[s]  = m_addr[am[s].owner];  e_be[s]    = m_be[am[s].owner];
          e_rd[s]    = m_rd[am[s].owner];    e_wr[s]    = m_wr[am[s].owner];
          e_wdata[s] = m_wdata[am[s].owner]; e_bc[s]    = m_bc[am[s].owner];
        end
      end
      for (int m = 0; m < NM; m++) begin
        int o;
        o = owned_by(m);
        msk[m]     = (o >= 0) || m_rd[m] || m_wr[m];
        e_wait[m]  = msk[m] && ((o >= 0) ? s_wait[o] : (dec(m_addr[m]) >= 0));
        e_rdata[m] = (msk[m] && o >= 0) ? s_rdata[o] : '0;
        a_wait[m]  = msk[m] && m_wait[m];
        a_rdata[m] = msk[m] ? m_rdata[m] : '0;
      end
      chk("mon_s_addr", s_addr, e_addr);
      chk("mon_s_be", s_be, e_be);
      chk("mon_s_rd", s_rd, e_rd);
      chk("mon_s_wr", s_wr, e_wr);
      chk("mon_s_wdata", s_wdata, e_wdata);
      chk("mon_s_bc", s_bc, e_bc);
      chk("mon_m_wait", a_wait, e_wait);
      chk("mon_m_rdata", a_rdata, e_rdata);
    end
  end

  // accepted write beats at slaves 0 and 1
  int unsigned cap0[$];
  int unsigned cap1[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_wr[0] && !s_wait[0]) cap0.push_back(s_wdata[0]);
      if (s_wr[1] && !s_wait[1]) cap1.push_back(s_wdata[1]);
    end
  end

  // ---------------- drive helpers
  task automatic clr();
    m_addr = '0; m_be = '1; m_rd = '0; m_wr = '0; m_wdata = '0; m_bc = '0;
    s_wait = '0; s_rdata = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) until master m has a beat accepted; optionally watch another stalled master
  task automatic wait_acc(input int m, input int other);
    bit done;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (other >= 0) chk("held_wait", m_wait[other], 1'b1);
      if (!m_wait[m]) done = 1;
      nxt();
    end
    chk("beat_accepted", done, 1'b1);
  endtask

  task automatic chk_cap0(input string nm, input int unsigned exp[$]);
    chk({nm, "_count"}, cap0.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap0.size(); i++) chk({nm, "_beat"}, cap0[i], exp[i]);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              ewait;
    logic [NS-1:0]     estrobe;
  } vec_t;
  vec_t vt [8];

  initial begin
    int unsigned got[$];
    int unsigned exp_g[$];

    vt[0] = '{30'h0000000, 1'b1, 5'b00001};
    vt[1] = '{30'h1FFFFFF, 1'b1, 5'b00001};
    vt[2] = '{30'h2000000, 1'b1, 5'b00010};
    vt[3] = '{30'h4000123, 1'b1, 5'b00100};
    vt[4] = '{30'h6000000, 1'b1, 5'b01000};
    vt[5] = '{30'h9FFFFFF, 1'b1, 5'b10000};
    vt[6] = '{30'hA000000, 1'b0, 5'b00000};
    vt[7] = '{30'h3FFFFFFF, 1'b0, 5'b00000};

    clr();
    rst_n = 1'b0;
    repeat (3) nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_s_rd", s_rd, '0);
    chk("reset_s_wr", s_wr, '0);
    nxt();

    // decode table: one single-beat read from master 3 per entry
    for (int i = 0; i < 8; i++) begin
      clr();
      m_addr[3] = vt[i].addr; m_rd[3] = 1'b1;
      @(negedge clk); chk("tbl_wait", m_wait[3], vt[i].ewait);
      nxt();
      @(negedge clk); chk("tbl_strobe", s_rd, vt[i].estrobe);
      nxt();
      m_rd[3] = 1'b0;
      nxt();
    end

    // M0 4-beat write with pause vs M1 single write, same cycle, slave 0
    clr(); cap0.delete();
    m_wr[0] = 1'b1; m_bc[0] = 8'd4; m_wdata[0] = 32'd1;
    m_wr[1] = 1'b1; m_bc[1] = 8'd1; m_wdata[1] = 32'hA;
    @(negedge clk);
    chk("s1_m0_wait_first", m_wait[0], 1'b1);
    chk("s1_slave_idle", s_wr[0], 1'b0);
    nxt();
    for (int d = 1; d <= 4; d++) begin
      if (d == 3) begin
        m_wr[0] = 1'b0;
        @(negedge clk);
        chk("s1_pause_wr", s_wr[0], 1'b0);
        chk("s1_pause_m1", m_wait[1], 1'b1);
        nxt();
        m_wr[0] = 1'b1;
      end
      m_wdata[0] = d;
      wait_acc(0, 1);
    end
    m_wr[0] = 1'b0;
    chk("s1_m0_only", cap0.size(), 4);
    wait_acc(1, -1);
    m_wr[1] = 1'b0;
    chk_cap0("s1_data", '{1, 2, 3, 4, 32'hA});

    // read burst of 4, slave stalls 3 cycles per beat
    clr();
    m_rd[0] = 1'b1; m_bc[0] = 8'd4; s_wait[0] = 1'b1; s_rdata[0] = 32'hBAD;
    nxt();
    for (int b = 0; b < 4; b++) begin
      repeat (3) begin
        @(negedge clk);
        chk("s2_wait_hi", m_wait[0], 1'b1);
        chk("s2_rd_strobe", s_rd[0], 1'b1);
        nxt();
      end
      s_wait[0] = 1'b0; s_rdata[0] = 32'h100 + b;
      @(negedge clk);
      chk("s2_rdata", m_rdata[0], 32'h100 + b);
      chk("s2_wait_lo", m_wait[0], 1'b0);
      nxt();
      s_wait[0] = 1'b1;
    end
    m_rd[0] = 1'b0; m_rd[1] = 1'b1; m_bc[1] = 8'd1; s_wait[0] = 1'b0;
    @(negedge clk); chk("s2_released", s_rd[0], 1'b0);
    nxt();
    @(negedge clk);
    chk("s2_next_grant", s_rd[0], 1'b1);
    chk("s2_next_wait", m_wait[1], 1'b0);
    nxt();
    m_rd[1] = 1'b0;
    nxt();

    // concurrent: M0 burst to slave 0, M1 single to slave 1
    clr(); cap0.delete(); cap1.delete();
    m_wr[0] = 1'b1; m_bc[0] = 8'd4; m_wdata[0] = 32'd5;
    m_addr[1] = 30'h2000000; m_wr[1] = 1'b1; m_bc[1] = 8'd1; m_wdata[1] = 32'hA;
    nxt();
    @(negedge clk);
    chk("s3_both_wr", s_wr[1:0], 2'b11);
    chk("s3_both_nowait", m_wait[1:0], 2'b00);
    nxt();
    m_wr[1] = 1'b0;
    for (int d = 6; d <= 8; d++) begin
      m_wdata[0] = d;
      @(negedge clk); chk("s3_m0_nowait", m_wait[0], 1'b0);
      nxt();
    end
    m_wr[0] = 1'b0;
    chk_cap0("s3_data", '{5, 6, 7, 8});
    chk("s3_s1_count", cap1.size(), 1);
    if (cap1.size() > 0) chk("s3_s1_data", cap1[0], 32'hA);

    // unmapped read
    clr();
    s_rdata = {NS{32'hDEADBEEF}};
    m_addr[2] = 30'h3FFFFFFF; m_rd[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("s4_wait", m_wait[2], 1'b0);
      chk("s4_rdata", m_rdata[2], 32'h0);
      chk("s4_no_rd", s_rd, '0);
      chk("s4_no_wr", s_wr, '0);
      nxt();
    end
    clr();
    nxt();

    // reset in the middle of a 4-beat burst, then a fresh burst
    clr(); cap0.delete();
    m_wr[0] = 1'b1; m_bc[0] = 8'd4; m_wdata[0] = 32'd1;
    nxt();
    wait_acc(0, -1);
    m_wdata[0] = 32'd2;
    wait_acc(0, -1);
    m_wdata[0] = 32'd3;
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1; m_wdata[0] = 32'h21;
    @(negedge clk);
    chk("s6_wr_idle", s_wr[0], 1'b0);
    chk("s6_m0_wait", m_wait[0], 1'b1);
    nxt();
    for (int d = 32'h21; d <= 32'h24; d++) begin
      m_wdata[0] = d;
      wait_acc(0, -1);
    end
    m_wr[0] = 1'b0;
    chk_cap0("s6_data", '{1, 2, 32'h21, 32'h22, 32'h23, 32'h24});

    // arbitration order among three masters hammering slave 0
    clr();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    for (int m = 0; m < 3; m++) begin
      m_wr[m] = 1'b1; m_bc[m] = 8'd1; m_wdata[m] = 32'h10 + m;
    end
    for (int n = 0; n < 30 && got.size() < 4; n++) begin
      @(negedge clk);
      if (s_wr[0] && !s_wait[0]) got.push_back(s_wdata[0] - 32'h10);
      nxt();
    end
`ifdef XBAR_ROUND_ROBIN_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    chk("s5_ngrants", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("s5_order", got[i], exp_g[i]);
    clr();
    nxt();

    // randomized traffic, model compares every cycle
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < NM; m++) begin
        if ($urandom_range(0, 3) == 0) begin
          logic [4:0] sel;
          int op;
          sel = 5'($urandom_range(0, 6));
          op  = $urandom_range(0, 2);
          m_addr[m]  = {sel, 25'($urandom)};
          m_be[m]    = 4'($urandom);
          m_rd[m]    = (op == 1);
          m_wr[m]    = (op == 2);
          m_bc[m]    = 8'($urandom_range(0, 3));
          m_wdata[m] = $urandom;
        end
      end
      s_wait = 5'($urandom) & 5'($urandom);
      for (int s = 0; s < NS; s++) s_rdata[s] = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      nxt();
    end
    rst_n = 1'b1;
    clr();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
